bht_update_ctrl: RTL and testbench

//  Owns the 2-bit branch history table (BHT) and schedules its single access port between two requesters.
//  - Lookup requester: the IF-stage predictor, a read.
//  - Update requester: resolved branches from EX, a read-modify-write (RMW).

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bht_update_ctrl_if.sv | 18 +
 rtl/bht_update_ctrl_upd_fifo.sv | 36 +++
 rtl/bht_update_ctrl.sv | 66 ++++++
 tb/tb_bht_update_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared BHT sizes, counter/update-entry types, FSM states and saturating counter helpers
package bp_pkg;
  localparam int IDX_W = 10;
  typedef logic [1:0] bht_cnt_t;
  typedef logic [IDX_W-1:0] bht_idx_t;
  localparam bht_cnt_t BHT_INIT = 2'b01;
  typedef struct packed {
    bht_idx_t idx;
    logic     taken;
  } upd_entry_t;
  typedef enum logic {INIT, RUN} ctrl_state_t;
  function automatic bht_cnt_t sat_inc(bht_cnt_t c);
    return &c ? c : c + 2'd1;
  endfunction
  function automatic bht_cnt_t sat_dec(bht_cnt_t c);
    return |c ? c - 2'd1 : c;
  endfunction
  function automatic bht_cnt_t bht_step(bht_cnt_t c, logic t);
    return t ? sat_inc(c) : sat_dec(c);
  endfunction
endpackage

// File: rtl/bht_update_ctrl_if.sv
// bht_update_ctrl_if: lookup (lk_valid/lk_pc -> lk_grant/lk_counter/lk_taken), update (upd_valid/upd_pc/upd_taken -> upd_ready) and init_busy; master = requesters, slave = BHT
interface bht_update_ctrl_if;
  import bp_pkg::*;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_grant;
  bht_cnt_t    lk_counter;
  logic        lk_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        init_busy;
  modport master (output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken,
                  input lk_grant, lk_counter, lk_taken, upd_ready, init_busy);
  modport slave (input lk_valid, lk_pc, upd_valid, upd_pc, upd_taken,
                 output lk_grant, lk_counter, lk_taken, upd_ready, init_busy);
endinterface

// File: rtl/bht_update_ctrl_upd_fifo.sv
// upd_fifo: sync FIFO of upd_entry_t; ports clk, rst, push/din, pop, full, empty, count, ents (contents oldest-first, ents[0] = head)
module upd_fifo import bp_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  upd_entry_t             din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output upd_entry_t [DEPTH-1:0] ents
);
  upd_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_comb
    for (int i = 0; i < DEPTH; i++) ents[i] = mem[rd + AW'(i)];
endmodule

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: 2-bit BHT with init sweep, one port shared by IF lookups and buffered EX updates; ports clk, rst, bus (slave); BHT_FWD_EN forwards the youngest pending update into lookups
module bht_update_ctrl import bp_pkg::*; #(
  parameter int       UPD_DEPTH = 4,
  parameter bht_cnt_t INIT_CNT = BHT_INIT
) (
  input logic clk,
  input logic rst,
  bht_update_ctrl_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int AW = $clog2(UPD_DEPTH);
  ctrl_state_t state;
  bht_idx_t sweep_idx, lk_idx;
  bht_cnt_t bht [ENTRIES];
  bht_cnt_t raw, cnt;
  logic full, empty, run, drain;
  logic [AW:0] count;
  upd_entry_t [UPD_DEPTH-1:0] ents;
  logic unused_pc;
  assign run = state == RUN;
  assign lk_idx = bus.lk_pc[IDX_W+1:2];
  assign raw = bht[lk_idx];
  assign drain = run & ~empty & (full | ~bus.lk_valid);
  assign bus.upd_ready = run & ~full;
  assign bus.lk_grant = run & bus.lk_valid & ~full;
  assign bus.lk_counter = bus.lk_grant ? cnt : '0;
  assign bus.lk_taken = bus.lk_grant & bus.lk_counter[1];
  assign unused_pc = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0], bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};
  upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.upd_valid & bus.upd_ready),
    .din('{idx: bus.upd_pc[IDX_W+1:2], taken: bus.upd_taken}),
    .pop(drain),
    .full(full),
    .empty(empty),
    .count(count),
    .ents(ents)
  );
`ifdef BHT_FWD_EN
  always_comb begin
    cnt = raw;
    for (int i = 0; i < UPD_DEPTH; i++)
      if ((AW+1)'(i) < count && ents[i].idx == lk_idx) cnt = bht_step(raw, ents[i].taken);
  end
`else
  logic unused_fwd;
  assign cnt = raw;
  assign unused_fwd = ^{count, ents};
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      sweep_idx <= '0;
      bus.init_busy <= 1'b1;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      state <= &sweep_idx ? RUN : INIT;
      bus.init_busy <= ~&sweep_idx;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      if (!run) bht[sweep_idx] <= INIT_CNT;
      else if (drain) bht[ents[0].idx] <= bht_step(bht[ents[0].idx], ents[0].taken);
    end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb_bht_update_ctrl: randomized and directed checks of bht_update_ctrl against a queue/array reference model
module tb_bht_update_ctrl;
  import bp_pkg::*;
`ifdef BHT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int ENTRIES = 1 << IDX_W;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  bht_update_ctrl_if bus();
  bht_update_ctrl #(.UPD_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int tbl [ENTRIES];
  int q_idx [$];
  bit q_t [$];
  int o_grant, o_cnt, o_taken, o_ready;
  int up [3] = '{2, 3, 3};
  int dn [4] = '{2, 1, 0, 0};
  int hot [6] = '{0, 1, 'h80, 'h3ff, 5, 'h40};
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int nxt(int c, bit t);
    return t ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
  endfunction
  function automatic int idx_of(logic [31:0] pc);
    return int'(pc[IDX_W+1:2]);
  endfunction
  function automatic logic [31:0] rpc();
    logic [IDX_W-1:0] i;
    i = IDX_W'(hot[$urandom_range(0, 5)]);
    return {20'($urandom), i, 2'($urandom)};
  endfunction
  task automatic drive(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, bit ut);
    bit full, grant, drain;
    int e, li;
    bus.lk_valid = lv;
    bus.lk_pc = lpc;
    bus.upd_valid = uv;
    bus.upd_pc = upc;
    bus.upd_taken = ut;
    full = q_idx.size() == DEPTH;
    grant = lv && !full;
    li = idx_of(lpc);
    e = tbl[li];
    if (FWD)
      for (int i = 0; i < q_idx.size(); i++)
        if (q_idx[i] == li) e = nxt(tbl[li], q_t[i]);
    if (!grant) e = 0;
    drain = q_idx.size() > 0 && (full || !lv);
    @(negedge clk);
    o_grant = int'(bus.lk_grant);
    o_cnt = int'(bus.lk_counter);
    o_taken = int'(bus.lk_taken);
    o_ready = int'(bus.upd_ready);
    chk("lk_grant", o_grant, int'(grant));
    chk("lk_counter", o_cnt, e);
    chk("lk_taken", o_taken, e >> 1);
    chk("upd_ready", o_ready, int'(!full));
    @(posedge clk);
    #1;
    if (drain) begin
      tbl[q_idx[0]] = nxt(tbl[q_idx[0]], q_t[0]);
      q_idx.delete(0);
      q_t.delete(0);
    end
    if (uv && !full) begin
      q_idx.push_back(idx_of(upc));
      q_t.push_back(ut);
    end
  endtask
  task automatic upd(logic [31:0] pc, bit t);
    drive(1'b0, 32'h0, 1'b1, pc, t);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic look(logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic do_reset();
    int n = 0;
    rst = 1'b1;
    bus.lk_valid = 1'b0;
    bus.lk_pc = '0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_taken = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_idx.delete();
    q_t.delete();
    chk("rst_init_busy", int'(bus.init_busy), 1);
    chk("rst_upd_ready", int'(bus.upd_ready), 0);
    chk("rst_lk_grant", int'(bus.lk_grant), 0);
    chk("rst_lk_counter", int'(bus.lk_counter), 0);
    chk("rst_lk_taken", int'(bus.lk_taken), 0);
    while (bus.init_busy && n < 2000) begin
      bus.lk_valid = 1'($urandom);
      bus.lk_pc = $urandom;
      bus.upd_valid = 1'($urandom);
      bus.upd_pc = $urandom;
      bus.upd_taken = 1'($urandom);
      @(negedge clk);
      chk("init_lk_grant", int'(bus.lk_grant), 0);
      chk("init_lk_taken", int'(bus.lk_taken), 0);
      chk("init_upd_ready", int'(bus.upd_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_cycles", n, ENTRIES);
    foreach (tbl[i]) tbl[i] = 1;
  endtask
  initial begin
    do_reset();
    look(32'h0);
    chk("init_value_0", o_cnt, 1);
    look(32'hfff_fffc);
    chk("init_value_last", o_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      upd(32'h100, 1'b1);
      look(32'h100);
      chk("sat_up_cnt", o_cnt, up[i]);
      chk("sat_up_taken", o_taken, 1);
    end
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b0);
      look(32'h100);
      chk("sat_dn_cnt", o_cnt, dn[i]);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h100, 1'b1, 32'h400 + 32'(i * 4), 1'b1);
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    chk("arb_full_grant", o_grant, 0);
    chk("arb_full_ready", o_ready, 0);
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    chk("arb_after_drain_grant", o_grant, 1);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(32'h200);
    chk("burst_same_idx", o_cnt, 3);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h0, 1'b1, 32'h100, 1'b1);
    do_reset();
    repeat (2) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(32'h100);
    chk("mid_reset_discard", o_cnt, 1);
    drive(1'b1, 32'h300, 1'b1, 32'h300, 1'b1);
    chk("fwd_before_push", o_cnt, 1);
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
`ifdef BHT_FWD_EN
    chk("fwd_pending", o_cnt, 2);
`else
    chk("fwd_pending", o_cnt, 1);
`endif
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(32'h300);
    chk("fwd_drained", o_cnt, 2);
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 99) < ((k / 500) % 2 ? 85 : 30), rpc(),
            $urandom_range(0, 99) < ((k / 300) % 2 ? 80 : 40), rpc(), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
